axi_master_bridge: RTL

- Upstream neighbour of the SRAM slave wrapper: converts one CPU-side memory request (load or store) into a single-beat AXI4 master transaction.
- Reads issue AR then collect R; writes issue AW and W concurrently, then collect B.
- One outstanding transaction at a time; the CPU pipeline stalls on req_ready low.

---
 rtl/axi_master_bridge.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_bridge.sv
// CPU load/store request -> single-beat AXI4 master transaction, one outstanding at a time.
// Latency: capture to rsp_valid 3 cycles with a zero-wait slave (2 with AXI_MASTER_RSP_BYPASS_EN).
// Backpressure: req_ready is high only in IDLE; AXI channels wait on their READY/VALID partners.
module axi_master_bridge #(
    parameter logic [3:0] ID_VAL = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            AWID,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [3:0]            BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [3:0]            ARID,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [3:0]            RID,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

`ifdef AXI_MASTER_RSP_BYPASS_EN
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
`endif

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                first_q;
    logic                aw_done;
    logic                w_done;
    logic                req_ready_q;
    logic                arvalid_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                rready_q;
    logic                bready_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                r_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                r_err;
    logic                b_err;
    logic [DATA_W-1:0]   fin_rdata;

    always_comb begin
        r_hs      = rready_q & RVALID;
        aw_hs     = awvalid_q & AWREADY;
        w_hs      = wvalid_q & WREADY;
        // The first beat is the one that carries the load data and the ID check.
        r_err     = first_q ? ((RRESP != 2'b00) | (RID != ID_VAL)) : (err_q | (RRESP != 2'b00));
        b_err     = (BRESP != 2'b00) | (BID != ID_VAL);
        fin_rdata = first_q ? RDATA : rdata_q;
    end

`ifdef AXI_MASTER_RSP_BYPASS_EN
    logic r_fin;
    logic b_fin;

    always_comb begin
        r_fin = (state == RD_DATA) & r_hs & RLAST;
        b_fin = (state == WR_RESP) & bready_q & BVALID;
    end

    assign rsp_valid = r_fin | b_fin;
    assign rsp_rdata = r_fin ? fin_rdata : rsp_rdata_q;
    assign rsp_err   = r_fin ? r_err : (b_fin ? b_err : rsp_err_q);
`else
    logic rsp_valid_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifndef AXI_MASTER_RSP_BYPASS_EN
            rsp_valid_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        first_q     <= 1'b1;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        first_q <= 1'b0;
                        err_q   <= r_err;
                        if (first_q) begin
                            rdata_q <= RDATA;
                        end
                        if (RLAST) begin
                            rready_q    <= 1'b0;
                            rsp_rdata_q <= fin_rdata;
                            rsp_err_q   <= r_err;
`ifdef AXI_MASTER_RSP_BYPASS_EN
                            req_ready_q <= 1'b1;
                            state       <= IDLE;
`else
                            rsp_valid_q <= 1'b1;
                            state       <= DONE;
`endif
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        bready_q  <= 1'b0;
                        rsp_err_q <= b_err;
`ifdef AXI_MASTER_RSP_BYPASS_EN
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
`else
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
`endif
                    end
                end
`ifndef AXI_MASTER_RSP_BYPASS_EN
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign AWID      = ID_VAL;
    assign AWADDR    = addr_q & ~ADDR_W'(3);
    assign AWLEN     = 4'd0;
    assign AWSIZE    = 3'b010;
    assign AWBURST   = 2'b01;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = 1'b1;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARID      = ID_VAL;
    assign ARADDR    = addr_q & ~ADDR_W'(3);
    assign ARLEN     = 4'd0;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule
